// File: rtl/ldpc_pkg.sv
// Shared constants and types for the LDPC variable-node datapath.
// Message format is signed Q(INT).(FRAC); saturation is symmetric so the most negative code never appears.
package ldpc_pkg;

    localparam int INT  = 8;
    localparam int FRAC = 8;
    localparam int W    = INT + FRAC;
    localparam int DV   = 3;
    localparam int DC   = 5;
    localparam int N    = 155;
    localparam int M    = 93;

    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (W-1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {
        S_CHAN = 2'd0,
        S_MSG  = 2'd1,
        S_OUT  = 2'd2
    } vn_state_e;

endpackage

// File: rtl/vn_sat.sv
// Saturating subtract: wide signed minuend minus W-bit signed subtrahend,
// clamped symmetrically to +/-(2^(W-1)-1).
module vn_sat #(
    parameter int AW = 18,
    parameter int W  = 16
) (
    input  logic [AW-1:0] minuend,
    input  logic [W-1:0]  subtrahend,
    output logic [W-1:0]  result
);

    // One guard bit above the accumulator width so the difference itself can never wrap.
    localparam int DW = AW + 1;
    localparam logic signed [DW-1:0] HI = {{(DW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [DW-1:0] LO = -HI;

    logic signed [DW-1:0] diff;

    always_comb begin
        diff = $signed({minuend[AW-1], minuend})
             - $signed({{(DW-W){subtrahend[W-1]}}, subtrahend});
        if (diff > HI) begin
            result = HI[W-1:0];
        end else if (diff < LO) begin
            result = LO[W-1:0];
        end else begin
            result = diff[W-1:0];
        end
    end

endmodule

// File: rtl/vn_serial.sv
// Serial LDPC variable node: takes a channel LLR plus DV check messages, then emits
// DV extrinsic variable-to-check messages with the saturated a-posteriori LLR and hard decision.
module vn_serial #(
    parameter int INT  = 8,
    parameter int FRAC = 8,
    parameter int DV   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT+FRAC-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT+FRAC-1:0]  out_data,
    output logic                 out_last,
    output logic [INT+FRAC-1:0]  app_llr,
    output logic                 hard_bit
);

    import ldpc_pkg::vn_state_e;
    import ldpc_pkg::S_CHAN;
    import ldpc_pkg::S_MSG;
    import ldpc_pkg::S_OUT;

    localparam int W  = INT + FRAC;
    localparam int AW = W + $clog2(DV + 1);
    localparam int CW = (DV > 1) ? $clog2(DV) : 1;

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // ready never depends on valid, and output fields hold until the beat moves.
    vn_state_e            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic signed [AW-1:0] acc, acc_nxt;
    logic [W-1:0]         msg_buf [DV];
    logic                 buf_we;
    logic                 last_cnt;
    logic signed [AW-1:0] in_ext;
    logic [W-1:0]         ext_sat;
    logic [W-1:0]         app_sat;

    assign last_cnt = (cnt == CW'(DV - 1));
    assign in_ext   = {{(AW-W){in_data[W-1]}}, in_data};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        buf_we    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_CHAN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt   = in_ext;
                    cnt_nxt   = '0;
                    state_nxt = S_MSG;
                end
            end
            S_MSG: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we  = 1'b1;
                    acc_nxt = acc + in_ext;
                    if (last_cnt) begin
                        cnt_nxt   = '0;
                        state_nxt = S_OUT;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_cnt) begin
                        cnt_nxt   = '0;
                        state_nxt = S_CHAN;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_CHAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CHAN;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DV; i++) begin
                msg_buf[i] <= '0;
            end
        end else if (buf_we) begin
            msg_buf[cnt] <= in_data;
        end
    end

    // Extrinsic message excludes the receiving check's own contribution.
    vn_sat #(.AW(AW), .W(W)) u_sat_ext (
        .minuend    (acc),
        .subtrahend (msg_buf[cnt]),
        .result     (ext_sat)
    );

    vn_sat #(.AW(AW), .W(W)) u_sat_app (
        .minuend    (acc),
        .subtrahend ('0),
        .result     (app_sat)
    );

    // Outputs are forced to zero outside S_OUT so idle and reset look identical downstream.
    assign out_data = out_valid ? ext_sat : '0;
    assign app_llr  = out_valid ? app_sat : '0;
    assign out_last = out_valid & last_cnt;
    assign hard_bit = out_valid & acc[AW-1];

endmodule

// File: tb/tb_vn_serial.sv
// Bench for vn_serial: directed vector table, multi-cycle corner sequences, and random
// frames checked against an arithmetic reference model through an expected-output queue.
module tb_vn_serial;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [W-1:0] app_llr;
    logic         hard_bit;

    vn_serial #(.INT(8), .FRAC(8), .DV(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .app_llr   (app_llr),
        .hard_bit  (hard_bit)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [W+1:0] side_q[$];   // {last, hard_bit, app_llr}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic last, input logic hb,
                            input logic [W-1:0] app);
        exp_q.push_back(d);
        side_q.push_back({last, hb, app});
    endtask

    function automatic int sat_i(input int v);
        if (v > 32767) return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    // Reference: total of all inputs; each outgoing message is the total minus its own input.
    task automatic push_model(input logic [W-1:0] llr, input logic [W-1:0] m0,
                              input logic [W-1:0] m1, input logic [W-1:0] m2);
        int m[3];
        int tot;
        m[0] = int'($signed(m0));
        m[1] = int'($signed(m1));
        m[2] = int'($signed(m2));
        tot  = int'($signed(llr)) + m[0] + m[1] + m[2];
        for (int k = 0; k < 3; k++) begin
            push_exp(W'(sat_i(tot - m[k])), k == 2, tot < 0, W'(sat_i(tot)));
        end
    endtask

    bit ov_arm = 0;
    int first_ov_cyc = -1;

    always @(negedge clk) begin
        logic [W+1:0] side;
        if (rst_n && out_valid) begin
            if (ov_arm) begin
                first_ov_cyc = cyc;
                ov_arm = 0;
            end
            check("in_ready_low_in_out", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                side = side_q[0];
                check("out_data", {16'b0, out_data}, {16'b0, exp_q[0]});
                check("out_last", {31'b0, out_last}, {31'b0, side[W+1]});
                check("hard_bit", {31'b0, hard_bit}, {31'b0, side[W]});
                check("app_llr", {16'b0, app_llr}, {16'b0, side[W-1:0]});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(side_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [W-1:0] d, input bit bubble, output int xfer_cyc);
        int guard = 0;
        if (bubble) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        xfer_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] llr, input logic [W-1:0] m0,
                              input logic [W-1:0] m1, input logic [W-1:0] m2,
                              input bit hold, input bit bubbles, output int chan_cyc);
        int c;
        send_beat(llr, bubbles && ($urandom_range(0, 3) == 0), chan_cyc);
        send_beat(m0, bubbles && ($urandom_range(0, 3) == 0), c);
        send_beat(m1, bubbles && ($urandom_range(0, 3) == 0), c);
        send_beat(m2, bubbles && ($urandom_range(0, 3) == 0), c);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_out_last"}, {31'b0, out_last}, 32'd0);
        check({tag, "_out_data"}, {16'b0, out_data}, 32'd0);
        check({tag, "_app_llr"}, {16'b0, app_llr}, 32'd0);
        check({tag, "_hard_bit"}, {31'b0, hard_bit}, 32'd0);
    endtask

    function automatic logic [W-1:0] rand_msg();
        int r = $urandom_range(0, 9);
        case (r)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return W'($urandom_range(16'h6000, 16'h7FFF));
            3:       return W'($urandom_range(16'h8000, 16'h9FFF));
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [W-1:0] llr;
        logic [W-1:0] m0;
        logic [W-1:0] m1;
        logic [W-1:0] m2;
        logic [W-1:0] o0;
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        logic [W-1:0] app;
        logic         hb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int c0, c1, c2, cdummy, guard;
        logic [W-1:0] rm[4];

        tbl[0] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0080, 16'h0380, 16'h0200, 16'h0280, 1'b0};
        tbl[1] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        tbl[2] = '{16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        tbl[5] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 1'b1};
        tbl[7] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Directed vectors.
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) begin
            push_exp(tbl[i].o0, 1'b0, tbl[i].hb, tbl[i].app);
            push_exp(tbl[i].o1, 1'b0, tbl[i].hb, tbl[i].app);
            push_exp(tbl[i].o2, 1'b1, tbl[i].hb, tbl[i].app);
            send_frame(tbl[i].llr, tbl[i].m0, tbl[i].m1, tbl[i].m2, 1'b0, 1'b0, cdummy);
            drain("vec_drain");
        end

        // Output stall: first beat must hold while out_ready is low.
        rdy_mode = 2;
        @(negedge clk);
        push_exp(tbl[0].o0, 1'b0, tbl[0].hb, tbl[0].app);
        push_exp(tbl[0].o1, 1'b0, tbl[0].hb, tbl[0].app);
        push_exp(tbl[0].o2, 1'b1, tbl[0].hb, tbl[0].app);
        send_frame(tbl[0].llr, tbl[0].m0, tbl[0].m1, tbl[0].m2, 1'b0, 1'b0, cdummy);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("stall_out_valid_seen", {31'b0, out_valid}, 32'd1);
        repeat (4) @(negedge clk);
        check("stall_queue_held", exp_q.size(), 32'd3);
        rdy_mode = 0;
        drain("stall_drain");

        // Reset in the middle of a frame discards it.
        @(negedge clk);
        send_beat(16'h1234, 1'b0, cdummy);
        send_beat(16'h0567, 1'b0, cdummy);
        send_beat(16'h0089, 1'b0, cdummy);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("mid_post_reset");
        push_exp(16'hFF00, 1'b0, 1'b0, 16'h0000);
        push_exp(16'h0100, 1'b0, 1'b0, 16'h0000);
        push_exp(16'h0000, 1'b1, 1'b0, 16'h0000);
        send_frame(16'h0000, 16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0, cdummy);
        drain("reset_frame_drain");

        // Back-to-back frames with in_valid held high: latency and period.
        @(negedge clk);
        ov_arm = 1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) rm[j] = rand_msg();
            push_model(rm[0], rm[1], rm[2], rm[3]);
            if (k == 0) send_frame(rm[0], rm[1], rm[2], rm[3], 1'b1, 1'b0, c0);
            else if (k == 1) send_frame(rm[0], rm[1], rm[2], rm[3], 1'b1, 1'b0, c1);
            else send_frame(rm[0], rm[1], rm[2], rm[3], 1'b0, 1'b0, c2);
        end
        drain("b2b_drain");
        check("first_out_latency", first_ov_cyc - c0, 32'd4);
        check("frame_period_0", c1 - c0, 32'd7);
        check("frame_period_1", c2 - c1, 32'd7);

        // Random frames with random backpressure and input bubbles.
        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            for (int j = 0; j < 4; j++) rm[j] = rand_msg();
            push_model(rm[0], rm[1], rm[2], rm[3]);
            send_frame(rm[0], rm[1], rm[2], rm[3], 1'($urandom_range(0, 1)), 1'b1, cdummy);
        end
        in_valid = 1'b0;
        drain("random_drain");
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vn_serial.md
VN_SERIAL -- requirements
Module: vn_serial

Interface
REQ-001 SHALL have parameter INT, default 8, integer bits of a message.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of a message; W = INT+FRAC.
REQ-003 SHALL have parameter DV, default 3, variable-node degree (number of check-to-variable messages).
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts input beat.
REQ-008 in_data  in  W  signed two's-complement LLR/message, Q(INT).(FRAC).
REQ-009 out_valid  out  1  output beat valid.
REQ-010 out_ready  in  1  downstream accepts output beat.
REQ-011 out_data  out  W  variable-to-check message, signed, same format.
REQ-012 out_last  out  1  marks final (DV-th) output beat.
REQ-013 app_llr  out  W  saturated a-posteriori LLR; valid while out_valid.
REQ-014 hard_bit  out  1  hard decision; valid while out_valid.

Function
REQ-015 Input frame SHALL be DV+1 beats: beat 0 channel LLR, beats 1..DV check-to-variable messages 0..DV-1; a beat transfers when in_valid and in_ready are both high.
REQ-016 FSM states SHALL be S_CHAN, S_MSG, S_OUT; in_ready = 1 in S_CHAN and S_MSG, 0 in S_OUT; out_valid = 1 only in S_OUT.
REQ-017 S_CHAN: on transfer, accumulator <= sign-extended in_data, cnt <= 0, go to S_MSG.
REQ-018 S_MSG: on transfer, buf[cnt] <= in_data, accumulator += in_data, cnt++; on transfer with cnt == DV-1, cnt <= 0 and go to S_OUT.
REQ-019 Accumulator SHALL be W+clog2(DV+1) bits; no intermediate overflow.
REQ-020 In S_OUT, out_data SHALL equal sat(accumulator - buf[cnt]); out_last = (cnt == DV-1).
REQ-021 sat() SHALL clamp symmetrically to [-(2^(W-1)-1), +(2^(W-1)-1)]; 0x8000 (W=16) is never output.
REQ-022 app_llr SHALL equal sat(accumulator); hard_bit = 1 iff accumulator < 0 (zero maps to 0).
REQ-023 On out_valid and out_ready, cnt increments; on the beat with out_last, go to S_CHAN with cnt <= 0.
REQ-024 First out_valid SHALL assert the cycle after the last message transfer; while out_ready is low, out_data, out_last, app_llr, hard_bit SHALL hold stable.
REQ-025 Minimum frame period SHALL be 2*DV+1 cycles; no input is accepted during S_OUT.

Reset
REQ-026 On rst_n low, state <= S_CHAN, cnt <= 0, accumulator <= 0, buf <= 0, asynchronously.
REQ-027 During and after reset, in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, app_llr = 0, hard_bit = 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next transferred beat is a channel LLR.

Structure
REQ-029 Package ldpc_pkg SHALL hold INT, FRAC, W, DV=3, DC=5, N=155, M=93, the state enum, and the saturation limits.
REQ-030 Saturating subtract SHALL be sub-module vn_sat (wide in, W-bit out), instantiated once for out_data and once for app_llr (subtrahend 0).

Verification
REQ-031 llr 0x0100, msgs 0x0200, 0xFF00, 0x0080, out_ready=1 -> outputs 0x0080, 0x0380, 0x0200; out_last on 3rd; app_llr 0x0280; hard_bit 0.
REQ-032 llr and all msgs 0x7000 -> each out_data 0x7FFF, app_llr 0x7FFF, hard_bit 0.
REQ-033 llr and all msgs 0x9000 -> each out_data 0x8001, app_llr 0x8001, hard_bit 1.
REQ-034 Scenario REQ-031 with out_ready low 5 cycles at first output -> out_data held 0x0080, in_ready 0 throughout, then 3 beats complete normally.
REQ-035 rst_n pulsed after 2 message transfers -> in_ready 1, out_valid 0; following frame llr 0, msgs 0x0100, 0xFF00, 0 -> outputs 0xFF00, 0x0100, 0x0000, app_llr 0, hard_bit 0.
REQ-036 Back-to-back frames with in_valid held high -> first out_valid 4 cycles after first input transfer, frame period 7 cycles.
